exc_sequencer: RTL and testbench
================================

# exc_sequencer

Commit-point exception and interrupt sequencer for the 5-stage pipeline. It sits between the memory stage and the CP0 register file:
- samples each committing instruction's exception flags, the pending-interrupt line from CP0 and ERET;
- resolves priority and emits one CP0 update pulse (exception or ERET2pc);
- flushes the pipeline and drives a handshaked PC redirect to fetch.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception entry PC
- DRAIN_CYCLES, 1, cycles flush is held after the CP0 pulse before redirect is offered (1..7)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- m_valid  in  1  an instruction is committing this cycle
- m_pc  in  32  PC of the committing instruction
- m_in_delay_slot  in  1  committing instruction is in a branch delay slot
- m_exc  in  6  flags {if_adel, ri, sys, bp, ov, mem_ade}
- m_is_store  in  1  qualifies mem_ade as AdES (1) or AdEL (0)
- m_data_addr  in  32  faulting data address
- m_eret  in  1  committing instruction is ERET
- interrupt  in  1  CP0 pending-and-enabled interrupt
- cp0_epc  in  32  current EPC from CP0
- redirect_ready  in  1  fetch accepts redirect
- exception  out  1  CP0 exception pulse
- m_excCode  out  6  ExcCode to CP0 (bit 5 always 0)
- isBadAddr  out  1  BadVAddr write enable to CP0
- invalid_addr  out  32  BadVAddr value
- excPC  out  32  faulting PC to CP0
- inDelaySlot  out  1  BD flag to CP0
- ERET2pc  out  1  CP0 ERET pulse
- flush  out  1  kill all in-flight instructions
- redirect_valid  out  1  redirect offered
- redirect_pc  out  32  redirect target
- exc_count  out  32  traps taken (see Configuration)

## Operation
- FSM states: IDLE, TRAP, DRAIN, REDIRECT.
- A trigger is a cycle with m_valid=1 in IDLE and at least one of: any m_exc bit, interrupt, m_eret. When m_valid=0, inputs are ignored; an interrupt is only taken on a valid instruction.
- Priority, highest first:
  - interrupt: Int, 0x00
  - if_adel: AdEL, 0x04, BadVAddr=m_pc
  - ri: RI, 0x0A
  - sys: Sys, 0x08
  - bp: Bp, 0x09
  - ov: Ov, 0x0C
  - mem_ade: AdES 0x05 / AdEL 0x04, BadVAddr=m_data_addr
  - m_eret, only when no higher entry is present
- On a trap trigger:
  - register the code, excPC=m_pc, inDelaySlot=m_in_delay_slot and the BadVAddr fields;
  - set redirect_pc=EXC_VECTOR;
  - go to TRAP.
- On an ERET trigger: register redirect_pc=cp0_epc, sampled in the trigger cycle; go to TRAP.
- TRAP (1 cycle):
  - exception=1 for a trap, or ERET2pc=1 for ERET;
  - isBadAddr=1 only for if_adel or mem_ade;
  - flush=1.
  - Next state: DRAIN.
- DRAIN: flush=1 for DRAIN_CYCLES cycles, counted by a 3-bit down-counter, then REDIRECT.
- REDIRECT: flush=1 and redirect_valid=1, with redirect_pc stable. On redirect_ready=1: return to IDLE in the next cycle and drop both signals.
- Triggers in any non-IDLE state are ignored; flush guarantees they are wrong-path.
- excPC is the raw instruction PC. CP0 applies the delay-slot −4 adjustment itself.

## Timing
- Latency from trigger cycle N:
  - CP0 pulse in cycle N+1;
  - redirect_valid first high in N+2+DRAIN_CYCLES;
  - minimum 4 cycles from trigger to IDLE when ready is already high.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset (asynchronous, any state):
  - state=IDLE;
  - all 1-bit outputs 0;
  - m_excCode=0, invalid_addr=0, excPC=0, redirect_pc=0, exc_count=0.
- A reset asserted in REDIRECT drops redirect_valid immediately; no CP0 pulse is replayed.
- exception and ERET2pc are never high in the same cycle. Each is high for exactly one cycle per trigger.
- redirect_ready in IDLE, TRAP or DRAIN is ignored.

## Configuration
- EXC_SEQ_PERF_EN defined:
  - exc_count increments by 1, wrapping at 2^32, in every TRAP cycle that asserts exception;
  - ERET does not count.
- EXC_SEQ_PERF_EN undefined: exc_count is tied to 0 and no counter flops exist.

## Test plan
- Overflow: m_valid=1, m_exc=6'b000010, m_pc=0x8000_1000, delay slot 0 → cycle+1: exception=1, m_excCode=0x0C, excPC=0x8000_1000, isBadAddr=0. Cycle+3: redirect_valid=1, redirect_pc=0xBFC0_0380.
- Fetch AdEL with ri and ov also set, in a delay slot, m_pc=0x8000_0003 → m_excCode=0x04, isBadAddr=1, invalid_addr=0x8000_0003, inDelaySlot=1.
- Interrupt=1 plus m_eret=1 on the same valid instruction → exception=1, code 0x00; ERET2pc stays 0.
- ERET with cp0_epc=0x8000_2000; redirect_ready held 0 for 5 cycles → ERET2pc pulses once; redirect_valid and flush are held with redirect_pc=0x8000_2000 until ready; IDLE one cycle after acceptance.
- Second trigger (m_exc sys) presented during DRAIN and REDIRECT → no second pulse; exc_count advances by exactly 1 with PERF enabled.
- resetn deasserted to 0 mid-REDIRECT → all outputs 0 immediately; after release, a new sys trap produces m_excCode=0x08 normally.

Source files
------------

// File: rtl/exc_sequencer.sv
// Commit-point exception/interrupt sequencer: picks the highest-priority trap (or ERET), then pulses CP0, flushes and redirects fetch.
// Latency: CP0 pulse 1 cycle after the trigger; redirect_valid at N+2+DRAIN_CYCLES; at least 4 cycles from trigger back to IDLE.
// Backpressure: redirect_valid/redirect_pc/flush are held until redirect_ready; triggers arriving outside IDLE are dropped.
//
// Ports: clk/resetn (async active-low); m_* commit-stage inputs, interrupt, cp0_epc;
//        CP0 side: exception, ERET2pc, m_excCode, isBadAddr, invalid_addr, excPC, inDelaySlot;
//        fetch side: flush, redirect_valid/redirect_pc with redirect_ready; exc_count.
// Optional feature: define EXC_SEQ_PERF_EN to build the 32-bit trap counter on exc_count;
// when undefined exc_count is tied to zero.
module exc_sequencer #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned DRAIN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_in_delay_slot,
    input  logic [5:0]  m_exc,
    input  logic        m_is_store,
    input  logic [31:0] m_data_addr,
    input  logic        m_eret,
    input  logic        interrupt,
    input  logic [31:0] cp0_epc,
    input  logic        redirect_ready,
    output logic        exception,
    output logic [5:0]  m_excCode,
    output logic        isBadAddr,
    output logic [31:0] invalid_addr,
    output logic [31:0] excPC,
    output logic        inDelaySlot,
    output logic        ERET2pc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] exc_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP,
        S_DRAIN,
        S_REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        exception_q, exception_d;
    logic        eret2pc_q, eret2pc_d;
    logic        bad_q, bad_d;
    logic [5:0]  code_q, code_d;
    logic [31:0] badaddr_q, badaddr_d;
    logic [31:0] excpc_q, excpc_d;
    logic        ds_q, ds_d;
    logic        flush_q, flush_d;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;

    // Priority decode of the committing instruction.
    logic        trap_hit;
    logic [5:0]  dec_code;
    logic        dec_bad;
    logic [31:0] dec_badaddr;

    assign trap_hit = interrupt | (|m_exc);

    always_comb begin
        dec_code    = 6'h00;
        dec_bad     = 1'b0;
        dec_badaddr = m_pc;
        if (interrupt) begin
            dec_code = 6'h00;
        end else if (m_exc[5]) begin
            dec_code = 6'h04;
            dec_bad  = 1'b1;
        end else if (m_exc[4]) begin
            dec_code = 6'h0A;
        end else if (m_exc[3]) begin
            dec_code = 6'h08;
        end else if (m_exc[2]) begin
            dec_code = 6'h09;
        end else if (m_exc[1]) begin
            dec_code = 6'h0C;
        end else if (m_exc[0]) begin
            dec_code    = m_is_store ? 6'h05 : 6'h04;
            dec_bad     = 1'b1;
            dec_badaddr = m_data_addr;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exception_d = 1'b0;
        eret2pc_d   = 1'b0;
        bad_d       = 1'b0;
        code_d      = code_q;
        badaddr_d   = badaddr_q;
        excpc_d     = excpc_q;
        ds_d        = ds_q;
        flush_d     = flush_q;
        rv_d        = 1'b0;
        rpc_d       = rpc_q;
        case (state_q)
            S_IDLE: begin
                flush_d = 1'b0;
                if (m_valid && (trap_hit || m_eret)) begin
                    state_d = S_TRAP;
                    flush_d = 1'b1;
                    if (trap_hit) begin
                        // A trap always wins over an ERET on the same instruction.
                        exception_d = 1'b1;
                        code_d      = dec_code;
                        excpc_d     = m_pc;
                        ds_d        = m_in_delay_slot;
                        bad_d       = dec_bad;
                        if (dec_bad) begin
                            badaddr_d = dec_badaddr;
                        end
                        rpc_d = EXC_VECTOR;
                    end else begin
                        eret2pc_d = 1'b1;
                        rpc_d     = cp0_epc;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_DRAIN;
                cnt_d   = 3'(DRAIN_CYCLES);
                flush_d = 1'b1;
            end
            S_DRAIN: begin
                flush_d = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = S_REDIRECT;
                    rv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = S_IDLE;
                    flush_d = 1'b0;
                end else begin
                    rv_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            exception_q <= 1'b0;
            eret2pc_q   <= 1'b0;
            bad_q       <= 1'b0;
            code_q      <= 6'h00;
            badaddr_q   <= 32'h0;
            excpc_q     <= 32'h0;
            ds_q        <= 1'b0;
            flush_q     <= 1'b0;
            rv_q        <= 1'b0;
            rpc_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exception_q <= exception_d;
            eret2pc_q   <= eret2pc_d;
            bad_q       <= bad_d;
            code_q      <= code_d;
            badaddr_q   <= badaddr_d;
            excpc_q     <= excpc_d;
            ds_q        <= ds_d;
            flush_q     <= flush_d;
            rv_q        <= rv_d;
            rpc_q       <= rpc_d;
        end
    end

`ifdef EXC_SEQ_PERF_EN
    // exception_q is high exactly during the TRAP cycle of a trap, never for ERET.
    logic [31:0] perf_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_q <= 32'h0;
        end else if (exception_q) begin
            perf_q <= perf_q + 32'd1;
        end
    end
    assign exc_count = perf_q;
`else
    assign exc_count = 32'h0;
`endif

    assign exception      = exception_q;
    assign ERET2pc        = eret2pc_q;
    assign isBadAddr      = bad_q;
    assign m_excCode      = code_q;
    assign invalid_addr   = badaddr_q;
    assign excPC          = excpc_q;
    assign inDelaySlot    = ds_q;
    assign flush          = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_exc_sequencer.sv
module tb_exc_sequencer;

    localparam int D = 1;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_in_delay_slot;
    logic [5:0]  m_exc;
    logic        m_is_store;
    logic [31:0] m_data_addr;
    logic        m_eret;
    logic        interrupt;
    logic [31:0] cp0_epc;
    logic        redirect_ready;
    logic        exception;
    logic [5:0]  m_excCode;
    logic        isBadAddr;
    logic [31:0] invalid_addr;
    logic [31:0] excPC;
    logic        inDelaySlot;
    logic        ERET2pc;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] exc_count;

    exc_sequencer #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_pc(m_pc),
        .m_in_delay_slot(m_in_delay_slot), .m_exc(m_exc), .m_is_store(m_is_store),
        .m_data_addr(m_data_addr), .m_eret(m_eret), .interrupt(interrupt),
        .cp0_epc(cp0_epc), .redirect_ready(redirect_ready), .exception(exception),
        .m_excCode(m_excCode), .isBadAddr(isBadAddr), .invalid_addr(invalid_addr),
        .excPC(excPC), .inDelaySlot(inDelaySlot), .ERET2pc(ERET2pc), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_eret;
        logic [5:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic        bad;
        logic [31:0] badaddr;
        int          cyc;
    } cp0_exp_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } rd_exp_t;

    cp0_exp_t cq[$];
    rd_exp_t  rq[$];

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every CP0 pulse and redirect against the scoreboard.
    logic prev_rv = 1'b0;
    logic idle_chk = 1'b0;
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (exception && ERET2pc) check("both_pulses", 32'd1, 32'd0);
            if (isBadAddr && !exception) check("badaddr_no_exc", 32'd1, 32'd0);
            if (exception || ERET2pc) begin
                if (cq.size() == 0) begin
                    check("unexpected_pulse", {exception, ERET2pc}, 32'd0);
                end else begin
                    cp0_exp_t e;
                    e = cq.pop_front();
                    check("pulse_kind", {31'd0, ERET2pc}, {31'd0, e.is_eret});
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_flush", {31'd0, flush}, 32'd1);
                    if (!e.is_eret) begin
                        check("excCode", {26'd0, m_excCode}, {26'd0, e.code});
                        check("excPC", excPC, e.pc);
                        check("inDelaySlot", {31'd0, inDelaySlot}, {31'd0, e.ds});
                        check("isBadAddr", {31'd0, isBadAddr}, {31'd0, e.bad});
                        if (e.bad) check("invalid_addr", invalid_addr, e.badaddr);
                    end
                end
            end
            if (idle_chk) begin
                check("idle_after_accept", {flush, redirect_valid}, 32'd0);
                idle_chk = 1'b0;
            end
            if (redirect_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_redirect", 32'd1, 32'd0);
                end else begin
                    if (!prev_rv) check("redirect_cycle", cyc, rq[0].cyc);
                    check("redirect_pc", redirect_pc, rq[0].pc);
                    check("redirect_flush", {31'd0, flush}, 32'd1);
                    if (redirect_ready) begin
                        void'(rq.pop_front());
                        idle_chk = 1'b1;
                    end
                end
            end
        end
        prev_rv = (resetn === 1'b1) ? redirect_valid : 1'b0;
    end

    task automatic drive_idle();
        m_valid = 1'b0; m_pc = 32'h0; m_in_delay_slot = 1'b0; m_exc = 6'h00;
        m_is_store = 1'b0; m_data_addr = 32'h0; m_eret = 1'b0; interrupt = 1'b0;
        cp0_epc = 32'h0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic ds, input logic [5:0] exc,
                         input logic st, input logic [31:0] da, input logic er,
                         input logic intr, input logic [31:0] epc,
                         input logic x_eret, input logic [5:0] x_code, input logic x_bad,
                         input logic [31:0] x_ba, input logic [31:0] x_rpc);
        cp0_exp_t e;
        rd_exp_t  r;
        @(posedge clk); #1;
        m_valid = 1'b1; m_pc = pc; m_in_delay_slot = ds; m_exc = exc; m_is_store = st;
        m_data_addr = da; m_eret = er; interrupt = intr; cp0_epc = epc;
        e.is_eret = x_eret; e.code = x_code; e.pc = pc; e.ds = ds; e.bad = x_bad;
        e.badaddr = x_ba; e.cyc = cyc + 1;
        r.pc = x_rpc; r.cyc = cyc + 2 + D;
        cq.push_back(e);
        rq.push_back(r);
`ifdef EXC_SEQ_PERF_EN
        if (!x_eret) exp_cnt++;
`endif
    endtask

    // Runs one trigger to completion; ready is raised after 'hold' redirect cycles.
    task automatic trig(input logic [31:0] pc, input logic ds, input logic [5:0] exc,
                        input logic st, input logic [31:0] da, input logic er,
                        input logic intr, input logic [31:0] epc,
                        input logic x_eret, input logic [5:0] x_code, input logic x_bad,
                        input logic [31:0] x_ba, input logic [31:0] x_rpc,
                        input int hold, input logic junk);
        int  w;
        bit  seen;
        bit  done;
        issue(pc, ds, exc, st, da, er, intr, epc, x_eret, x_code, x_bad, x_ba, x_rpc);
        if (hold == 0) redirect_ready = 1'b1;
        w = 0; seen = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            if (junk && flush) begin
                m_valid = 1'b1; m_exc = 6'b001000; m_pc = 32'hDEAD_0000; m_eret = 1'b0;
                interrupt = 1'b0;
            end else begin
                drive_idle();
            end
            if (redirect_valid) begin
                seen = 1; w++;
                if (w > hold) redirect_ready = 1'b1;
            end else if (seen) begin
                done = 1;
            end
        end
        redirect_ready = 1'b0;
        drive_idle();
        if (!done) check("trig_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit got_rv;
        resetn = 1'b0;
        redirect_ready = 1'b0;
        drive_idle();
        #1;
        check("rst_bits", {exception, ERET2pc, isBadAddr, inDelaySlot, flush, redirect_valid}, 32'd0);
        check("rst_code", {26'd0, m_excCode}, 32'd0);
        check("rst_badaddr", invalid_addr, 32'd0);
        check("rst_excpc", excPC, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_count", exc_count, 32'd0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        // Overflow, ready already high: minimum-latency path.
        trig(32'h8000_1000, 1'b0, 6'b000010, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
             1'b0, 6'h0C, 1'b0, 32'h0, VEC, 0, 1'b0);
        // Fetch AdEL beats ri and ov; delay slot; BadVAddr is the PC.
        trig(32'h8000_0003, 1'b1, 6'b110010, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h0,
             1'b0, 6'h04, 1'b1, 32'h8000_0003, VEC, 1, 1'b0);
        // Interrupt beats ERET on the same instruction.
        trig(32'h8000_3000, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_4444,
             1'b0, 6'h00, 1'b0, 32'h0, VEC, 1, 1'b0);
        // ERET with ready held low for 5 redirect cycles.
        trig(32'h8000_5000, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_2000,
             1'b1, 6'h00, 1'b0, 32'h0, 32'h8000_2000, 5, 1'b0);
        // Sys with a second sys trigger presented throughout the flush window.
        trig(32'h8000_6000, 1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
             1'b0, 6'h08, 1'b0, 32'h0, VEC, 2, 1'b1);
        // Data address errors (store/load), then breakpoint and ri.
        trig(32'h8000_7000, 1'b0, 6'b000001, 1'b1, 32'h0000_0102, 1'b0, 1'b0, 32'h0,
             1'b0, 6'h05, 1'b1, 32'h0000_0102, VEC, 0, 1'b0);
        trig(32'h8000_7004, 1'b1, 6'b000011, 1'b0, 32'h0000_0201, 1'b0, 1'b0, 32'h0,
             1'b0, 6'h0C, 1'b0, 32'h0, VEC, 0, 1'b0);
        trig(32'h8000_7008, 1'b0, 6'b000001, 1'b0, 32'h0000_0301, 1'b0, 1'b0, 32'h0,
             1'b0, 6'h04, 1'b1, 32'h0000_0301, VEC, 1, 1'b0);
        trig(32'h8000_700C, 1'b0, 6'b000101, 1'b0, 32'h0000_0401, 1'b0, 1'b0, 32'h0,
             1'b0, 6'h09, 1'b0, 32'h0, VEC, 0, 1'b0);
        trig(32'h8000_7010, 1'b0, 6'b011000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
             1'b0, 6'h0A, 1'b0, 32'h0, VEC, 0, 1'b0);

        // Invalid slots and an empty valid slot must not trigger.
        @(posedge clk); #1;
        m_exc = 6'b111111; interrupt = 1'b1; m_eret = 1'b1; m_valid = 1'b0;
        redirect_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 drive_idle(); m_valid = 1'b1;
        @(posedge clk); #1 drive_idle(); redirect_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("no_trigger_flush", {flush, redirect_valid}, 32'd0);
        check("count_before_reset", exc_count, exp_cnt);

        // Reset while the redirect is pending.
        issue(32'h8000_8000, 1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
              1'b0, 6'h08, 1'b0, 32'h0, VEC);
        got_rv = 0;
        for (int i = 0; i < 20 && !got_rv; i++) begin
            @(posedge clk); #1 drive_idle();
            if (redirect_valid) got_rv = 1;
        end
        check("rv_before_reset", {31'd0, got_rv}, 32'd1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("midrst_bits", {exception, ERET2pc, isBadAddr, inDelaySlot, flush, redirect_valid}, 32'd0);
        check("midrst_rpc", redirect_pc, 32'd0);
        check("midrst_excpc", excPC, 32'd0);
        check("midrst_count", exc_count, 32'd0);
        cq.delete();
        rq.delete();
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        trig(32'h8000_9000, 1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
             1'b0, 6'h08, 1'b0, 32'h0, VEC, 0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("cp0_queue_drained", cq.size(), 32'd0);
        check("redirect_queue_drained", rq.size(), 32'd0);
        check("final_count", exc_count, exp_cnt);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
